pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   pipe_state_e : controller FSM encoding (ST_RUN=0, ST_MEM_WAIT=1)
//   REG_IDX_W    : architectural register index width
//   REG_X0       : hard-wired zero register index (never a hazard source)
//   STG_*        : pipeline register indices, for debug/trace use
package pipe_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1
   } pipe_state_e;

   localparam int unsigned STG_PC     = 0;
   localparam int unsigned STG_IF_ID  = 1;
   localparam int unsigned STG_ID_EX  = 2;
   localparam int unsigned STG_EX_MEM = 3;
   localparam int unsigned STG_MEM_WB = 4;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard detector.
// Flags when the load in EX writes a register the instruction in ID reads.
//   id_rs1, id_rs2 : source indices of the ID instruction
//   id_uses_rs2    : ID instruction actually reads rs2
//   ex_memread     : EX instruction is a load
//   ex_rd          : EX destination index
//   load_use       : hazard present, one bubble required
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs2,
   input  logic                 ex_memread,
   input  logic [REG_IDX_W-1:0] ex_rd,
   output logic                 load_use
);

   // Writes to x0 are discarded, so they can never feed a dependent instruction.
   assign load_use = ex_memread && (ex_rd != REG_X0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch flushes resolved in MEM and
// multi-cycle data-memory accesses (dmem_req/dmem_ready handshake).
// Inputs : clk, arst_n (async active-low), id_rs1/id_rs2/id_uses_rs2,
//          ex_memread/ex_rd, mem_branch_taken, dmem_req, dmem_ready
// Outputs: en_pc/en_if_id/en_id_ex/en_ex_mem/en_mem_wb register enables,
//          flush_if_id/flush_id_ex/flush_ex_mem bubble strobes, pc_sel,
//          mem_timeout_err (sticky), state_o (debug)
// Optional: `define PIPE_CTRL_PERF_CNT_EN adds saturating stall_cycles and
//           flush_events counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs2,
   input  logic                 ex_memread,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 mem_branch_taken,
   input  logic                 dmem_req,
   input  logic                 dmem_ready,
   output logic                 en_pc,
   output logic                 en_if_id,
   output logic                 en_id_ex,
   output logic                 en_ex_mem,
   output logic                 en_mem_wb,
   output logic                 flush_if_id,
   output logic                 flush_id_ex,
   output logic                 flush_ex_mem,
   output logic                 pc_sel,
   output logic                 mem_timeout_err,
   output logic [1:0]           state_o
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_events
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   pipe_state_e      state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic             load_use;
   logic             resolve;     // pipeline may advance this cycle (rules 2-4)
   logic             en_front;    // PC and IF/ID enables
   logic             en_back;     // ID/EX, EX/MEM, MEM/WB enables
   logic             fl_if_id, fl_id_ex, fl_ex_mem, sel_branch;

   pipe_hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs2 (id_uses_rs2),
      .ex_memread  (ex_memread),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   // Next-state, wait counter and timeout flag.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      resolve    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (dmem_req && !dmem_ready) begin
               state_d = ST_MEM_WAIT;
            end else begin
               resolve = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!dmem_ready) begin
               if (wait_cnt_q != '1) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
               // Keep waiting after the error; it only reports the overrun.
               if (wait_cnt_q >= TIMEOUT_LAST) begin
                  err_d = 1'b1;
               end
            end else begin
               // Exit cycle: the frozen pipeline is resolved as if in RUN.
               resolve    = 1'b1;
               wait_cnt_d = '0;
               state_d    = ST_RUN;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Priority: branch flush beats load-use bubble; a memory stall beats both.
   always_comb begin
      en_front   = 1'b0;
      en_back    = 1'b0;
      fl_if_id   = 1'b0;
      fl_id_ex   = 1'b0;
      fl_ex_mem  = 1'b0;
      sel_branch = 1'b0;
      if (resolve) begin
         en_front = 1'b1;
         en_back  = 1'b1;
         if (mem_branch_taken) begin
            fl_if_id   = 1'b1;
            fl_id_ex   = 1'b1;
            fl_ex_mem  = 1'b1;
            sel_branch = 1'b1;
         end else if (load_use) begin
            en_front = 1'b0;
            fl_id_ex = 1'b1;
         end
      end
   end

   // Gate with reset so nothing in the pipeline moves while reset is held.
   assign en_pc        = arst_n & en_front;
   assign en_if_id     = arst_n & en_front;
   assign en_id_ex     = arst_n & en_back;
   assign en_ex_mem    = arst_n & en_back;
   assign en_mem_wb    = arst_n & en_back;
   assign flush_if_id  = arst_n & fl_if_id;
   assign flush_id_ex  = arst_n & fl_id_ex;
   assign flush_ex_mem = arst_n & fl_ex_mem;
   assign pc_sel       = arst_n & sel_branch;

   assign mem_timeout_err = err_q;
   assign state_o         = state_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q;
   logic [CNT_W-1:0] flush_events_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         if (!en_front && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
         end
         if (sel_branch && (flush_events_q != '1)) begin
            flush_events_q <= flush_events_q + 1'b1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

   // {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
   //  flush_if_id, flush_id_ex, flush_ex_mem, pc_sel}
   localparam logic [8:0] CTL_IDLE  = 9'b11111_000_0;
   localparam logic [8:0] CTL_LU    = 9'b00111_010_0;
   localparam logic [8:0] CTL_BR    = 9'b11111_111_1;
   localparam logic [8:0] CTL_STALL = 9'b00000_000_0;

   logic       clk, arst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs2, ex_memread, mem_branch_taken, dmem_req, dmem_ready;
   logic       en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
   logic       flush_if_id, flush_id_ex, flush_ex_mem, pc_sel, mem_timeout_err;
   logic [1:0] state_o;
   logic [8:0] ctrl;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   int total  = 0;
   int passed = 0;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (32)
   ) dut (
      .clk              (clk),
      .arst_n           (arst_n),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_uses_rs2      (id_uses_rs2),
      .ex_memread       (ex_memread),
      .ex_rd            (ex_rd),
      .mem_branch_taken (mem_branch_taken),
      .dmem_req         (dmem_req),
      .dmem_ready       (dmem_ready),
      .en_pc            (en_pc),
      .en_if_id         (en_if_id),
      .en_id_ex         (en_id_ex),
      .en_ex_mem        (en_ex_mem),
      .en_mem_wb        (en_mem_wb),
      .flush_if_id      (flush_if_id),
      .flush_id_ex      (flush_id_ex),
      .flush_ex_mem     (flush_ex_mem),
      .pc_sel           (pc_sel),
      .mem_timeout_err  (mem_timeout_err),
      .state_o          (state_o)
`ifdef PIPE_CTRL_PERF_CNT_EN
      ,
      .stall_cycles     (stall_cycles),
      .flush_events     (flush_events)
`endif
   );

   assign ctrl = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, pc_sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs change just after a falling edge; outputs are sampled 2 ns later.
   initial begin
      arst_n = 1'b0;  id_rs1 = '0;  id_rs2 = '0;  ex_rd = '0;
      id_uses_rs2 = 1'b0;  ex_memread = 1'b0;  mem_branch_taken = 1'b0;
      dmem_req = 1'b0;  dmem_ready = 1'b0;

      #3;
      check("rst_ctrl", 32'(ctrl), 32'(CTL_STALL));
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_err", 32'(mem_timeout_err), 32'd0);

      @(negedge clk); arst_n = 1'b1;
      #2 check("idle", 32'(ctrl), 32'(CTL_IDLE));

      // Load-use on rs1: exactly one bubble.
      @(negedge clk); ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
      #2 check("lu_rs1", 32'(ctrl), 32'(CTL_LU));
      @(negedge clk); ex_memread = 1'b0;
      #2 check("lu_clear", 32'(ctrl), 32'(CTL_IDLE));

      // x0 destination and unused rs2 never stall.
      @(negedge clk); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
      #2 check("lu_x0", 32'(ctrl), 32'(CTL_IDLE));
      @(negedge clk); ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
      #2 check("lu_rs2_unused", 32'(ctrl), 32'(CTL_IDLE));
      @(negedge clk); id_uses_rs2 = 1'b1;
      #2 check("lu_rs2", 32'(ctrl), 32'(CTL_LU));

      // Branch overrides simultaneous load-use.
      @(negedge clk); mem_branch_taken = 1'b1;
      #2 check("br_over_lu", 32'(ctrl), 32'(CTL_BR));

      // Multi-cycle memory access, branch pending during the wait.
      @(negedge clk); ex_memread = 1'b0; id_uses_rs2 = 1'b0; mem_branch_taken = 1'b0;
      dmem_req = 1'b1; dmem_ready = 1'b0;
      #2 check("mw_enter_ctrl", 32'(ctrl), 32'(CTL_STALL));
      check("mw_enter_state", 32'(state_o), 32'd0);
      @(negedge clk);
      #2 check("mw_w1_ctrl", 32'(ctrl), 32'(CTL_STALL));
      check("mw_w1_state", 32'(state_o), 32'd1);
      @(negedge clk); mem_branch_taken = 1'b1;
      #2 check("mw_w2_ctrl", 32'(ctrl), 32'(CTL_STALL));
      check("mw_w2_state", 32'(state_o), 32'd1);
      @(negedge clk); dmem_ready = 1'b1;
      #2 check("mw_exit_ctrl", 32'(ctrl), 32'(CTL_BR));
      check("mw_exit_state", 32'(state_o), 32'd1);
      @(negedge clk); dmem_req = 1'b0; dmem_ready = 1'b0; mem_branch_taken = 1'b0;
      #2 check("mw_after_ctrl", 32'(ctrl), 32'(CTL_IDLE));
      check("mw_after_state", 32'(state_o), 32'd0);
      check("mw_after_cnt", dut.wait_cnt_q, 32'd0);
      check("mw_after_err", 32'(mem_timeout_err), 32'd0);

      // Single-cycle access and stray ready.
      @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b1;
      #2 check("fast_ctrl", 32'(ctrl), 32'(CTL_IDLE));
      @(negedge clk);
      #2 check("fast_state", 32'(state_o), 32'd0);
      @(negedge clk); dmem_req = 1'b0;
      #2 check("stray_ready_ctrl", 32'(ctrl), 32'(CTL_IDLE));
      check("stray_ready_state", 32'(state_o), 32'd0);

      // Timeout: error appears after the fourth wait cycle and is sticky.
      @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b0;
      #2 check("to_enter_state", 32'(state_o), 32'd0);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         #2 check($sformatf("to_w%0d_state", i), 32'(state_o), 32'd1);
         check($sformatf("to_w%0d_err", i), 32'(mem_timeout_err), (i >= 5) ? 32'd1 : 32'd0);
      end
      @(negedge clk); dmem_ready = 1'b1;
      #2 check("to_exit_ctrl", 32'(ctrl), 32'(CTL_IDLE));
      check("to_exit_err", 32'(mem_timeout_err), 32'd1);
      @(negedge clk); dmem_req = 1'b0; dmem_ready = 1'b0;
      #2 check("to_run_state", 32'(state_o), 32'd0);
      check("to_run_err", 32'(mem_timeout_err), 32'd1);

      // Reset in the middle of a wait.
      @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 check("rw_state", 32'(state_o), 32'd1);
      check("rw_cnt", dut.wait_cnt_q, 32'd1);
      dmem_ready = 1'b1; arst_n = 1'b0;
      #1 check("rw_rst_ctrl", 32'(ctrl), 32'(CTL_STALL));
      check("rw_rst_state", 32'(state_o), 32'd0);
      check("rw_rst_cnt", dut.wait_cnt_q, 32'd0);
      check("rw_rst_err", 32'(mem_timeout_err), 32'd0);
      @(negedge clk); dmem_req = 1'b0; dmem_ready = 1'b0; arst_n = 1'b1;
      #2 check("rw_rel_ctrl", 32'(ctrl), 32'(CTL_IDLE));
      check("rw_rel_state", 32'(state_o), 32'd0);
      check("rw_rel_cnt", dut.wait_cnt_q, 32'd0);
      @(negedge clk);
      #2 check("rw_idle_ctrl", 32'(ctrl), 32'(CTL_IDLE));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
